// File: rtl/user_alu_pipe.sv
// Two-stage valid/ready ALU: S1 captures op/operands, S2 computes and registers result and flags.
// Optional running accumulator (opcodes ACC / ACC_LD) is built only when USER_ALU_ACC_EN is defined.
module user_alu_pipe #(
  parameter int               WIDTH     = 36,
  parameter logic [WIDTH-1:0] CONST_VAL = WIDTH'(36'h0DEADBEEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_err
);

  localparam logic [2:0] OP_XOR    = 3'd0;
  localparam logic [2:0] OP_AND    = 3'd1;
  localparam logic [2:0] OP_OR     = 3'd2;
  localparam logic [2:0] OP_ADD    = 3'd3;
  localparam logic [2:0] OP_SUB    = 3'd4;
  localparam logic [2:0] OP_CONST  = 3'd5;
  localparam logic [2:0] OP_ACC    = 3'd6;
  localparam logic [2:0] OP_ACC_LD = 3'd7;

  logic             s1_valid_r;
  logic [2:0]       s1_op_r;
  logic [WIDTH-1:0] s1_a_r;
  logic [WIDTH-1:0] s1_b_r;

  logic             adv_s;
  logic [WIDTH:0]   sum_s;
  logic [WIDTH:0]   diff_s;
  logic [WIDTH-1:0] res_s;
  logic             carry_s;
  logic             err_s;
  logic             zero_s;
  logic             acc_we_s;

  // S2 may load whenever its current result is absent or leaving this cycle.
  assign adv_s    = !out_valid || out_ready;
  assign in_ready = adv_s || !s1_valid_r;

  // Top bit of the extended difference is the unsigned borrow (a < b).
  assign sum_s  = {1'b0, s1_a_r} + {1'b0, s1_b_r};
  assign diff_s = {1'b0, s1_a_r} - {1'b0, s1_b_r};

`ifdef USER_ALU_ACC_EN
  logic [WIDTH-1:0] acc_r;
  logic [WIDTH:0]   acc_sum_s;

  assign acc_sum_s = {1'b0, acc_r} + {1'b0, s1_a_r};
`endif

  // Result, carry and error for the op held in S1.
  always_comb begin
    res_s    = {WIDTH{1'b0}};
    carry_s  = 1'b0;
    err_s    = 1'b0;
    acc_we_s = 1'b0;
    case (s1_op_r)
      OP_XOR:   res_s = s1_a_r ^ s1_b_r;
      OP_AND:   res_s = s1_a_r & s1_b_r;
      OP_OR:    res_s = s1_a_r | s1_b_r;
      OP_ADD:   {carry_s, res_s} = sum_s;
      OP_SUB:   {carry_s, res_s} = diff_s;
      OP_CONST: res_s = CONST_VAL;
`ifdef USER_ALU_ACC_EN
      OP_ACC: begin
        {carry_s, res_s} = acc_sum_s;
        acc_we_s         = 1'b1;
      end
      OP_ACC_LD: begin
        res_s    = s1_a_r;
        acc_we_s = 1'b1;
      end
`else
      OP_ACC:    err_s = 1'b1;
      OP_ACC_LD: err_s = 1'b1;
`endif
      default: begin
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        err_s   = 1'b1;
      end
    endcase
    zero_s = (res_s == {WIDTH{1'b0}});
  end

  // Stage 1: capture operands on an input transfer; hold while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_op_r    <= 3'd0;
      s1_a_r     <= {WIDTH{1'b0}};
      s1_b_r     <= {WIDTH{1'b0}};
    end else if (in_ready) begin
      s1_valid_r <= in_valid;
      if (in_valid) begin
        s1_op_r <= in_op;
        s1_a_r  <= in_a;
        s1_b_r  <= in_b;
      end
    end
  end

  // Stage 2: registered outputs, frozen while the consumer stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_res   <= {WIDTH{1'b0}};
      out_carry <= 1'b0;
      out_zero  <= 1'b0;
      out_err   <= 1'b0;
    end else if (adv_s) begin
      out_valid <= s1_valid_r;
      if (s1_valid_r) begin
        out_res   <= res_s;
        out_carry <= carry_s;
        out_zero  <= zero_s;
        out_err   <= err_s;
      end
    end
  end

`ifdef USER_ALU_ACC_EN
  // Accumulator commits only when S2 actually takes the op, so chained ACC ops see fresh values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r <= {WIDTH{1'b0}};
    end else if (adv_s && s1_valid_r && acc_we_s) begin
      acc_r <= res_s;
    end
  end
`endif

endmodule
